// File: rtl/if_fetch_ctrl.sv
// Fetch sequencer for a single-outstanding, multi-cycle instruction memory.
// Issues one read per instruction, stalls the PC until delivery, and handles redirects.
module if_fetch_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_pc,
    input  logic        i_b_exe,
    input  logic        i_hazard,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_rvalid,
    output logic [31:0] o_inst_out,
    output logic        o_inst_valid,
    output logic        o_fetch_stall,
    output logic        o_err_timeout,
    output logic        o_err_spurious
);

    localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDeliver,
        StDiscard
    } state_e;

    state_e      r_state;
    state_e      w_state_next;
    logic [7:0]  r_wait_cnt;
    logic [7:0]  w_wait_cnt_next;
    logic [7:0]  w_cnt_inc;
    logic        w_expire;
    logic [31:0] r_inst_out;
    logic [31:0] w_inst_next;
    logic        r_inst_valid;
    logic        r_err_timeout;
    logic        r_err_spurious;
    logic        w_req;
    logic        w_timeout_set;
    logic        w_spurious_set;

    assign w_cnt_inc = r_wait_cnt + 8'd1;
    // Fires on the cycle whose increment would bring the count to TIMEOUT.
    assign w_expire  = (w_cnt_inc == TimeoutCnt);

    always_comb begin
        w_state_next    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        w_inst_next     = r_inst_out;
        w_req           = 1'b0;
        w_timeout_set   = 1'b0;
        w_spurious_set  = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_spurious_set = i_mem_rvalid;
                if (!i_b_exe) begin
                    w_req           = 1'b1;
                    w_state_next    = StWait;
                    w_wait_cnt_next = 8'd0;
                end
            end
            StWait: begin
                if (i_b_exe) begin
                    if (i_mem_rvalid) begin
                        w_state_next = StIdle;
                    end else begin
                        w_state_next    = StDiscard;
                        w_wait_cnt_next = 8'd0;
                    end
                end else if (i_mem_rvalid) begin
                    w_inst_next  = i_mem_rdata;
                    w_state_next = StDeliver;
                end else if (w_expire) begin
                    w_timeout_set   = 1'b1;
                    w_state_next    = StIdle;
                    w_wait_cnt_next = w_cnt_inc;
                end else begin
                    w_wait_cnt_next = w_cnt_inc;
                end
            end
            StDeliver: begin
                w_spurious_set = i_mem_rvalid;
                if (i_b_exe || !i_hazard) begin
                    w_state_next = StIdle;
                end
            end
            StDiscard: begin
                if (i_mem_rvalid) begin
                    w_state_next = StIdle;
                end else if (w_expire) begin
                    w_timeout_set   = 1'b1;
                    w_state_next    = StIdle;
                    w_wait_cnt_next = w_cnt_inc;
                end else begin
                    w_wait_cnt_next = w_cnt_inc;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state        <= StIdle;
            r_wait_cnt     <= 8'd0;
            r_inst_out     <= 32'd0;
            r_inst_valid   <= 1'b0;
            r_err_timeout  <= 1'b0;
            r_err_spurious <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_wait_cnt     <= w_wait_cnt_next;
            r_inst_out     <= w_inst_next;
            r_inst_valid   <= (w_state_next == StDeliver);
            r_err_timeout  <= r_err_timeout | w_timeout_set;
            r_err_spurious <= r_err_spurious | w_spurious_set;
        end
    end

    // Reset overrides the combinational handshake so nothing leaks while held.
    assign o_mem_req      = i_rst & w_req;
    assign o_mem_addr     = i_pc;
    assign o_fetch_stall  = !i_rst | !(((r_state == StDeliver) && !i_hazard) || i_b_exe);
    assign o_inst_out     = r_inst_out;
    assign o_inst_valid   = r_inst_valid;
    assign o_err_timeout  = r_err_timeout;
    assign o_err_spurious = r_err_spurious;

endmodule
